// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// funct3 access-size codes, FSM state type and the alignment-check helper
// used by the optional misalignment trap (LSU_MISALIGN_CHK_EN).
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stores share the size encodings of the signed loads.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } lsu_state_t;

    // Halves must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
// Produces byte enables and lane-shifted store data for the bus, and
// extracts/extends the addressed byte or half from returned load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [15:0] lane;

    assign shamt = {offset, 3'b000};
    // Only the low 16 bits of the shifted read word are ever needed.
    assign lane  = 16'(load_raw >> shamt);

    // Store side: enables and replicated, shifted write data.
    // Words ignore the low address bits entirely.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}} << shamt;
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}} << shamt;
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        load_data = 32'h0;
        case (funct3[1:0])
            2'b00:   load_data = funct3[2] ? {24'h0, lane[7:0]}
                                           : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = funct3[2] ? {16'h0, lane}
                                           : {{16{lane[15]}}, lane};
            default: load_data = load_raw;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit, responder side of the ls_done handshake.
// Accepts one decoded load/store, runs a single req/gnt/rvalid bus
// transaction, writes back aligned load data and pulses ls_done.
// TIMEOUT > 0 aborts a stuck REQ/WAIT with ls_err.
// Optional: define LSU_MISALIGN_CHK_EN to trap misaligned half/word
// accesses instead of issuing them.
//
// state | meaning
// IDLE  | waiting for a decoded load/store
// REQ   | d_req held with stable fields until d_gnt
// WAIT  | load granted, waiting for d_rvalid
// DRAIN | flushed load still owed a d_rvalid; result discarded
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  dest,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm_signed,
    input  logic        flush,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic        d_gnt,
    input  logic        d_rvalid,
    input  logic [31:0] d_rdata,
    output logic        ls_done,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic        ls_err
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    lsu_state_t  state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  dest_q, dest_d;
    logic        load_q, load_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;

    logic [31:0] ea_in;
    logic        accept;
    logic        misalign;
    logic        timeout_hit;
    logic [31:0] cnt_inc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    assign ea_in  = rs1_val + imm_signed;
    assign accept = (state_q == IDLE) & ex_valid & (op_load | op_store) & ~flush;

`ifdef LSU_MISALIGN_CHK_EN
    assign misalign = is_misaligned(funct3, ea_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign cnt_inc     = cnt_q + 32'd1;
    assign timeout_hit = (TIMEOUT_W != 32'd0) && (cnt_inc == TIMEOUT_W);

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (ea_q[1:0]),
        .store_data (sdata_q),
        .load_raw   (d_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    // Request fields are zeroed outside REQ so idle outputs read as 0.
    assign d_req   = (state_q == REQ);
    assign d_we    = d_req & ~load_q;
    assign d_addr  = d_req ? {ea_q[31:2], 2'b00} : 32'h0;
    assign d_be    = d_req ? be : 4'b0000;
    assign d_wdata = d_req ? wdata : 32'h0;

    assign ls_done  = done_q;
    assign ls_err   = err_q;
    assign rd_we    = rd_we_q;
    assign rd_addr  = rd_addr_q;
    assign rd_wdata = rd_wdata_q;

    // Next-state, latch and one-cycle result pulse generation.
    always_comb begin
        state_d    = state_q;
        ea_d       = ea_q;
        f3_d       = f3_q;
        dest_d     = dest_q;
        load_d     = load_q;
        sdata_d    = sdata_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rd_we_d    = 1'b0;
        rd_addr_d  = 5'd0;
        rd_wdata_d = 32'h0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    ea_d    = ea_in;
                    f3_d    = funct3;
                    dest_d  = dest;
                    load_d  = op_load;
                    sdata_d = rs2_val;
                    cnt_d   = 32'd0;
                    if (misalign) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end

            REQ: begin
                if (d_gnt) begin
                    cnt_d = 32'd0;
                    if (flush) begin
                        // A granted store is already in memory; a granted
                        // load still owes us rvalid.
                        state_d = load_q ? DRAIN : IDLE;
                    end else if (load_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            WAIT: begin
                if (flush) begin
                    state_d = d_rvalid ? IDLE : DRAIN;
                end else if (d_rvalid) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    rd_we_d    = (dest_q != 5'd0);
                    rd_addr_d  = dest_q;
                    rd_wdata_d = load_data;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            DRAIN: begin
                if (d_rvalid) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ea_q       <= 32'h0;
            f3_q       <= 3'b000;
            dest_q     <= 5'd0;
            load_q     <= 1'b0;
            sdata_q    <= 32'h0;
            cnt_q      <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_wdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            f3_q       <= f3_d;
            dest_q     <= dest_d;
            load_q     <= load_d;
            sdata_q    <= sdata_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
        end
    end

endmodule
